// File: rtl/awgn_clt_gen.sv
// awgn_clt_gen: multi-channel central-limit AWGN source with a programmable gain, saturation and a valid/ready output.
// Optional macro SEED_LOAD_EN adds the seed_load/seed_in ports for run-time LFSR reseeding.
module awgn_clt_gen #(
  parameter int          NUM_CH    = 2,
  parameter int          OUT_W     = 16,
  parameter int          U_W       = 12,
  parameter int          NSUM      = 4,
  parameter int          GAIN_W    = 8,
  parameter int          GAIN_FRAC = 7,
  parameter logic [31:0] SEED      = 32'hACE1_2468
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [GAIN_W-1:0]       gain,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*OUT_W-1:0] noise_out,
  output logic [NUM_CH-1:0]       sat
`ifdef SEED_LOAD_EN
  ,
  input  logic                    seed_load,
  input  logic [31:0]             seed_in
`endif
);

  localparam int LOG_N  = $clog2(NSUM);
  localparam int CNT_W  = LOG_N;
  localparam int ACC_W  = U_W + LOG_N;
  localparam int PROD_W = ACC_W + GAIN_W + 1;
  localparam int EXT_W  = (PROD_W > OUT_W) ? PROD_W : OUT_W + 1;
  localparam logic [31:0] POLY = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, HOLD} state_t;

  state_t                    r_state, w_next;
  logic                      w_start;
  logic                      w_seed_load;
  logic [31:0]               w_seed_base;
  logic [CNT_W-1:0]          r_cnt;
  logic [GAIN_W-1:0]         r_gain;
  logic [31:0]               r_lfsr [NUM_CH];
  logic signed [ACC_W-1:0]   r_acc  [NUM_CH];
  logic [NUM_CH*OUT_W-1:0]   r_noise;
  logic [NUM_CH-1:0]         r_sat;

  // A zero base is promoted to 1 before rotation, so every channel gets a distinct non-zero seed.
  function automatic logic [31:0] f_seed(input logic [31:0] base, input int c);
    logic [31:0] b;
    logic [31:0] r;
    int          k;
    b = (base == 32'd0) ? 32'd1 : base;
    k = c % 32;
    r = (b << k) | (b >> (32 - k));
    r = r ^ 32'(c);
    if (r == 32'd0) r = 32'd1;
    return r;
  endfunction

  function automatic logic [31:0] f_lfsr_step(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? POLY : 32'd0);
  endfunction

  // Top U_W bits with the MSB inverted: offset-binary to zero-mean two's complement.
  function automatic logic signed [ACC_W-1:0] f_uniform(input logic [31:0] x);
    logic signed [U_W-1:0] u;
    u = {~x[31], x[30 -: U_W-1]};
    return ACC_W'(u);
  endfunction

  // Returns {sat, value}: floor-scaled product clipped to the signed OUT_W range.
  function automatic logic [OUT_W:0] f_scale_sat(input logic signed [ACC_W-1:0] acc,
                                                 input logic [GAIN_W-1:0]      g);
    logic signed [PROD_W-1:0] prod;
    logic signed [EXT_W-1:0]  shr;
    prod = PROD_W'(acc) * PROD_W'($signed({1'b0, g}));
    shr  = EXT_W'(prod >>> GAIN_FRAC);
    if ((&shr[EXT_W-1:OUT_W-1]) || !(|shr[EXT_W-1:OUT_W-1]))
      return {1'b0, shr[OUT_W-1:0]};
    else if (shr[EXT_W-1])
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

`ifdef SEED_LOAD_EN
  assign w_seed_load = seed_load;
  assign w_seed_base = seed_in;
`else
  assign w_seed_load = 1'b0;
  assign w_seed_base = SEED;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_start = 1'b1;
          w_next  = ACCUM;
        end
      end
      ACCUM: begin
        if (r_cnt == CNT_W'(NSUM-1)) w_next = SCALE;
      end
      SCALE: w_next = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (enable) begin
            w_start = 1'b1;
            w_next  = ACCUM;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
    if (w_seed_load) begin
      w_start = 1'b0;
      w_next  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_noise <= '0;
      r_sat   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_lfsr[c] <= f_seed(SEED, c);
        r_acc[c]  <= '0;
      end
    end else if (w_seed_load) begin
      r_cnt <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_lfsr[c] <= f_seed(w_seed_base, c);
        r_acc[c]  <= '0;
      end
    end else begin
      if (w_start) begin
        r_gain <= gain;
        r_cnt  <= '0;
        for (int c = 0; c < NUM_CH; c++) r_acc[c] <= '0;
      end
      // ACCUM: one uniform per channel per cycle, LFSRs advance only here
      if (r_state == ACCUM) begin
        r_cnt <= r_cnt + 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
          r_acc[c]  <= r_acc[c] + f_uniform(r_lfsr[c]);
          r_lfsr[c] <= f_lfsr_step(r_lfsr[c]);
        end
      end
      // SCALE: gain, floor shift and clip into the output register
      if (r_state == SCALE) begin
        for (int c = 0; c < NUM_CH; c++)
          {r_sat[c], r_noise[c*OUT_W +: OUT_W]} <= f_scale_sat(r_acc[c], r_gain);
      end
    end
  end

  assign out_valid = (r_state == HOLD);
  assign noise_out = r_noise;
  assign sat       = r_sat;

endmodule
